sbox_substitution_engine: RTL and testbench

- Downstream consumer of the chaotic S-box generator.
- Takes the generated 256-entry byte table over a serial write port, checks that it is a bijection, and builds the inverse table at the same time.
- Then substitutes a byte stream (forward or inverse) with valid/ready handshakes on both sides.
- Feeds the image/plaintext diffusion stage of the Mars cipher datapath.

---
 rtl/sbox_substitution_engine.sv | 142 ++++++++++++++
 tb/tb_sbox_substitution_engine.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_substitution_engine.sv
// -----------------------------------------------------------------------------
// sbox_substitution_engine
//
// Accepts a 256-entry byte S-box over a serial write port (index order 0..255),
// checks on the fly that every value is unique (bijection), and builds the
// inverse table in parallel with the forward one. Once loaded, it substitutes
// a byte stream through either table with valid/ready handshakes on both sides
// at up to one byte per cycle.
//
// enable_bar=1 freezes the whole block: no table writes, no handshakes, and
// all state and outputs hold their values.
// -----------------------------------------------------------------------------
module sbox_substitution_engine #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable_bar,
    input  logic                   load_start,
    input  logic                   sbox_wr_valid,
    input  logic [7:0]             sbox_wr_data,
    output logic                   load_done,
    output logic                   sbox_error,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    input  logic                   in_mode_inverse,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] bytes_processed
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_VALIDATE,
        S_READY,
        S_ERROR
    } state_t;

    state_t       state;
    logic [8:0]   wr_index;   // reaches 256 once the last entry is accepted
    logic [255:0] seen;       // one bit per byte value already written

    logic [7:0]   fwd_mem [256];
    logic [7:0]   inv_mem [256];

    logic         active;
    logic         wr_fire;
    logic         wr_dup;
    logic         in_fire;
    logic         out_fire;
    logic [7:0]   sub_byte;

    assign active   = !enable_bar;

    // The output register can take a new byte when it is empty or is being
    // drained in this same cycle, which gives 1 byte/cycle throughput.
    assign in_ready = active && (state == S_READY) && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = active && (state == S_READY) && out_valid && out_ready;

    // load_start wins over a same-cycle write, so the write is dropped.
    assign wr_fire  = active && !load_start && (state == S_LOAD) && sbox_wr_valid;
    assign wr_dup   = seen[sbox_wr_data];

    assign sub_byte = in_mode_inverse ? inv_mem[in_data] : fwd_mem[in_data];

    // Table write port: forward entry at the running index, inverse entry at the value.
    // NOTE: the table arrays are deliberately left without reset; a reset on a
    // RAM forces it into flops, and the contents are never used before a full
    // load has rewritten every entry anyway.
    always_ff @(posedge clk) begin
        if (wr_fire && !wr_dup) begin
            fwd_mem[wr_index[7:0]] <= sbox_wr_data;
            inv_mem[sbox_wr_data]  <= wr_index[7:0];
        end
    end

    // Control FSM with registered status, stream output and byte counter.
    // NOTE: every register here uses non-blocking assignment so all of them
    // update together on the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            wr_index        <= '0;
            seen            <= '0;
            load_done       <= 1'b0;
            sbox_error      <= 1'b0;
            out_valid       <= 1'b0;
            out_data        <= 8'h00;
            bytes_processed <= '0;
        end else if (active) begin
            if (load_start) begin
                state           <= S_LOAD;
                wr_index        <= '0;
                seen            <= '0;
                load_done       <= 1'b0;
                sbox_error      <= 1'b0;
                out_valid       <= 1'b0;   // pending output byte is discarded
                bytes_processed <= '0;
            end else begin
                unique case (state)
                    S_LOAD: begin
                        if (sbox_wr_valid) begin
                            if (wr_dup) begin
                                state      <= S_ERROR;
                                sbox_error <= 1'b1;
                            end else begin
                                seen[sbox_wr_data] <= 1'b1;
                                wr_index           <= wr_index + 9'd1;
                                if (wr_index == 9'd255) begin
                                    state <= S_VALIDATE;
                                end
                            end
                        end
                    end
                    S_VALIDATE: begin
                        state     <= S_READY;
                        load_done <= 1'b1;
                    end
                    S_READY: begin
                        if (in_fire) begin
                            out_valid <= 1'b1;
                            out_data  <= sub_byte;
                        end else if (out_fire) begin
                            out_valid <= 1'b0;
                        end
                        if (out_fire) begin
                            bytes_processed <= bytes_processed + COUNT_WIDTH'(1);
                        end
                    end
                    default: begin
                        // S_IDLE and S_ERROR wait for load_start; writes ignored.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sbox_substitution_engine.sv
// -----------------------------------------------------------------------------
// Testbench for sbox_substitution_engine.
// A behavioural model (tables as arrays, pending outputs as a queue) tracks
// what the engine should report every cycle; directed scenarios are followed
// by a randomized streaming phase.
// -----------------------------------------------------------------------------
module tb_sbox_substitution_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable_bar;
    logic        load_start;
    logic        sbox_wr_valid;
    logic [7:0]  sbox_wr_data;
    logic        load_done;
    logic        sbox_error;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_mode_inverse;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [31:0] bytes_processed;

    always #5 clk = ~clk;

    sbox_substitution_engine #(.COUNT_WIDTH(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable_bar      (enable_bar),
        .load_start      (load_start),
        .sbox_wr_valid   (sbox_wr_valid),
        .sbox_wr_data    (sbox_wr_data),
        .load_done       (load_done),
        .sbox_error      (sbox_error),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_mode_inverse (in_mode_inverse),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_ready       (out_ready),
        .bytes_processed (bytes_processed)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  fwd_m [256];
    logic [7:0]  inv_m [256];
    bit          seen_m [256];
    logic [7:0]  exp_q [$];
    logic [31:0] m_count;
    bit          m_ready, m_err, m_loading, m_validate;
    int          m_idx;
    bit          last_in_hs;
    logic [7:0]  tbl [256];

    task automatic model_reset();
        exp_q.delete();
        m_count    = 0;
        m_ready    = 0;
        m_err      = 0;
        m_loading  = 0;
        m_validate = 0;
        m_idx      = 0;
        foreach (seen_m[i]) seen_m[i] = 0;
    endtask

    // One clock cycle: compare at the falling edge, advance the model, then
    // return just after the rising edge so the caller can drive new inputs.
    task automatic cycle();
        bit en;
        bit exp_ir;
        @(negedge clk);
        en     = !enable_bar;
        exp_ir = en && m_ready && (exp_q.size() == 0 || out_ready);
        last_in_hs = 0;
        if (!load_start) check("in_ready", in_ready, exp_ir);
        check("out_valid", out_valid, exp_q.size() != 0);
        check("load_done", load_done, m_ready);
        check("sbox_error", sbox_error, m_err);
        check("bytes_processed", bytes_processed, m_count);
        if (exp_q.size() != 0) check("out_data", out_data, exp_q[0]);
        if (en) begin
            if (load_start) begin
                model_reset();
                m_loading = 1;
            end else begin
                if (m_ready) begin
                    if (exp_q.size() != 0 && out_ready) begin
                        void'(exp_q.pop_front());
                        m_count++;
                    end
                    if (in_valid && exp_ir) begin
                        exp_q.push_back(in_mode_inverse ? inv_m[in_data] : fwd_m[in_data]);
                        last_in_hs = 1;
                    end
                end
                if (m_validate) begin
                    m_validate = 0;
                    m_ready    = 1;
                end else if (m_loading && sbox_wr_valid) begin
                    if (seen_m[sbox_wr_data]) begin
                        m_err     = 1;
                        m_loading = 0;
                    end else begin
                        seen_m[sbox_wr_data] = 1;
                        fwd_m[m_idx]         = sbox_wr_data;
                        inv_m[sbox_wr_data]  = 8'(m_idx);
                        m_idx++;
                        if (m_idx == 256) begin
                            m_loading  = 0;
                            m_validate = 1;
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_table();
        load_start = 1;
        cycle();
        load_start = 0;
        for (int i = 0; i < 256; i++) begin
            sbox_wr_valid = 1;
            sbox_wr_data  = tbl[i];
            cycle();
        end
        sbox_wr_valid = 0;
        check("ld_lat_validate", load_done, 0);
        cycle();
        check("ld_lat_ready", load_done, 1);
    endtask

    task automatic random_perm();
        logic [7:0] t;
        for (int i = 0; i < 256; i++) tbl[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            int j;
            j = $urandom_range(i, 0);
            t = tbl[i]; tbl[i] = tbl[j]; tbl[j] = t;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic inv);
        in_valid        = 1;
        in_data         = b;
        in_mode_inverse = inv;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (last_in_hs) break;
        end
        check("send_accept", last_in_hs, 1);
        in_valid = 0;
    endtask

    initial begin
        reset = 0; enable_bar = 0; load_start = 0; sbox_wr_valid = 0; sbox_wr_data = 0;
        in_valid = 0; in_data = 0; in_mode_inverse = 0; out_ready = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_load_done", load_done, 0);
        check("rst_sbox_error", sbox_error, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_bytes", bytes_processed, 0);
        reset = 1;
        cycle();

        // Reversal table, forward stream at full rate
        for (int i = 0; i < 256; i++) tbl[i] = 8'(255 - i);
        load_table();
        send(8'h00, 0); check("rev_fwd_00", out_data, 8'hFF);
        send(8'h10, 0); check("rev_fwd_10", out_data, 8'hEF);
        send(8'hFF, 0); check("rev_fwd_FF", out_data, 8'h00);
        cycle();
        check("rev_count3", bytes_processed, 3);

        // Inverse lookups on two tables
        send(8'h3C, 1); check("rev_inv_3C", out_data, 8'hC3);
        cycle();
        for (int i = 0; i < 256; i++) tbl[i] = 8'((i + 1) % 256);
        load_table();
        send(8'h00, 1); check("inc_inv_00", out_data, 8'hFF);
        send(8'hFF, 0); check("inc_fwd_FF", out_data, 8'h00);
        cycle();

        // Duplicate value at index 7 (same as index 3)
        for (int i = 0; i < 256; i++) tbl[i] = 8'(i) ^ 8'h80;
        tbl[3] = 8'h05; tbl[7] = 8'h05;
        load_start = 1; cycle(); load_start = 0;
        for (int i = 0; i < 8; i++) begin
            sbox_wr_valid = 1; sbox_wr_data = tbl[i]; cycle();
        end
        check("dup_error", sbox_error, 1);
        check("dup_load_done", load_done, 0);
        for (int i = 8; i < 256; i++) begin
            sbox_wr_valid = 1; sbox_wr_data = tbl[i]; cycle();
        end
        sbox_wr_valid = 0;
        in_valid = 1; in_data = 8'h12;
        cycle(); cycle();
        check("dup_in_ready", in_ready, 0);
        check("dup_still_error", sbox_error, 1);
        in_valid = 0;
        load_start = 1; cycle(); load_start = 0;
        check("dup_cleared", sbox_error, 0);

        // Backpressure
        random_perm();
        load_table();
        out_ready = 0;
        send(8'hAA, 0);
        in_valid = 1; in_data = 8'hBB; in_mode_inverse = 0;
        repeat (3) cycle();
        check("bp_hold_data", out_data, tbl[8'hAA]);
        check("bp_in_ready", in_ready, 0);
        out_ready = 1;
        cycle();
        check("bp_accept", last_in_hs, 1);
        check("bp_next_data", out_data, tbl[8'hBB]);
        in_valid = 0;
        cycle();

        // Freeze with a pending output and a waiting input
        begin
            logic [31:0] cnt_before;
            out_ready = 0;
            send(8'h5A, 0);
            in_valid = 1; in_data = 8'h33; in_mode_inverse = 0;
            cnt_before = m_count;
            enable_bar = 1; out_ready = 1;
            repeat (5) begin
                cycle();
                check("en_hold_data", out_data, tbl[8'h5A]);
                check("en_hold_cnt", bytes_processed, cnt_before);
            end
            enable_bar = 0;
            cycle();
            check("en_resume_accept", last_in_hs, 1);
            check("en_resume_data", out_data, tbl[8'h33]);
            check("en_resume_cnt", bytes_processed, cnt_before + 1);
            in_valid = 0;
            cycle();
        end

        // Randomized streaming on a fresh random table
        random_perm();
        load_table();
        for (int c = 0; c < 600; c++) begin
            in_valid        = $urandom_range(1, 0);
            in_data         = 8'($urandom);
            in_mode_inverse = $urandom_range(1, 0);
            out_ready       = ($urandom_range(3, 0) != 0);
            enable_bar      = ($urandom_range(7, 0) == 0);
            cycle();
        end
        enable_bar = 0; in_valid = 0; out_ready = 1;
        cycle(); cycle();

        // Asynchronous reset in the middle of a load
        random_perm();
        load_start = 1; cycle(); load_start = 0;
        for (int i = 0; i < 100; i++) begin
            sbox_wr_valid = 1; sbox_wr_data = tbl[i]; cycle();
        end
        sbox_wr_valid = 0;
        reset = 0;
        #1;
        check("mid_rst_load_done", load_done, 0);
        check("mid_rst_sbox_error", sbox_error, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 8'h00);
        check("mid_rst_bytes", bytes_processed, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1;
        cycle();
        random_perm();
        load_table();
        check("reload_no_error", sbox_error, 0);
        for (int k = 0; k < 8; k++) send(8'($urandom), $urandom_range(1, 0));
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
